// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - WIDTH-bit word to LANES-wide serial stream with frame strobes
// One-word holding register feeds a shifter so consecutive frames run with no idle beat.
module lane_serializer #(
   parameter int WIDTH     = 64,
   parameter int LANES     = 1,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] parallel_i,
   output logic [LANES-1:0] serial_o,
   output logic             frame_o,
   output logic             frame_start_o,
   output logic             frame_end_o,
   output logic [15:0]      frame_count_o
);
   localparam int BEATS = WIDTH / LANES;
   localparam int CW    = $clog2(BEATS);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    beat_q, beat_d;
   logic [LANES-1:0] serial_q, serial_d;
   logic             frame_q, frame_d;
   logic             start_q, start_d;
   logic             end_q, end_d;
   logic [15:0]      count_q, count_d;
   logic             last_beat, load_now, accept;

   assign last_beat  = (state_q == SHIFT) && (beat_q == CW'(BEATS - 1));
   assign load_now   = enable_i & hold_full_q & ((state_q == IDLE) | last_beat);
   assign in_ready_o = rst_ni & enable_i & (~hold_full_q | load_now);
   assign accept     = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_now) state_d = SHIFT;
         SHIFT:   if (enable_i && last_beat && !load_now) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next state; output strobes are derived from the post-edge beat so they register cleanly.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shreg_d     = shreg_q;
      beat_d      = beat_q;
      count_d     = count_q;
      if (accept) begin
         hold_d      = parallel_i;
         hold_full_d = 1'b1;
      end else if (load_now) begin
         hold_full_d = 1'b0;
      end
      if (enable_i) begin
         if (last_beat) count_d = count_q + 16'd1;
         if (load_now) begin
            shreg_d = hold_q;
            beat_d  = '0;
         end else if (last_beat) begin
            beat_d = '0;
         end else if (state_q == SHIFT) begin
            beat_d  = beat_q + CW'(1);
            shreg_d = MSB_FIRST ? (shreg_q << LANES) : (shreg_q >> LANES);
         end
      end
      frame_d  = (state_d == SHIFT);
      serial_d = '0;
      if (frame_d) serial_d = MSB_FIRST ? shreg_d[WIDTH-1 -: LANES] : shreg_d[LANES-1:0];
      start_d = frame_d && (beat_d == '0);
      end_d   = frame_d && (beat_d == CW'(BEATS - 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shreg_q     <= '0;
         beat_q      <= '0;
         count_q     <= '0;
         serial_q    <= '0;
         frame_q     <= 1'b0;
         start_q     <= 1'b0;
         end_q       <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shreg_q     <= shreg_d;
         beat_q      <= beat_d;
         count_q     <= count_d;
         serial_q    <= serial_d;
         frame_q     <= frame_d;
         start_q     <= start_d;
         end_q       <= end_d;
      end
   end

   assign serial_o      = serial_q;
   assign frame_o       = frame_q;
   assign frame_start_o = start_q;
   assign frame_end_o   = end_q;
   assign frame_count_o = count_q;
endmodule

// File: tb/tb_lane_serializer.sv
// tb/tb_lane_serializer.sv - three serializer configurations against a queue-based frame model
module tb_lane_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en;
   logic        valid [3];
   logic [63:0] data  [3];
   logic        rdy [3], frm [3], fst [3], fend [3];
   logic [15:0] fc [3];
   logic        s0, s2;
   logic [3:0]  s1;
   logic [3:0]  ser [3];

   always_comb begin
      ser[0] = {3'b000, s0};
      ser[1] = s1;
      ser[2] = {3'b000, s2};
   end

   lane_serializer #(.WIDTH(64), .LANES(1), .MSB_FIRST(1'b1)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .in_valid_i(valid[0]), .in_ready_o(rdy[0]),
      .parallel_i(data[0]), .serial_o(s0), .frame_o(frm[0]), .frame_start_o(fst[0]),
      .frame_end_o(fend[0]), .frame_count_o(fc[0]));
   lane_serializer #(.WIDTH(64), .LANES(4), .MSB_FIRST(1'b0)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .in_valid_i(valid[1]), .in_ready_o(rdy[1]),
      .parallel_i(data[1]), .serial_o(s1), .frame_o(frm[1]), .frame_start_o(fst[1]),
      .frame_end_o(fend[1]), .frame_count_o(fc[1]));
   lane_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .in_valid_i(valid[2]), .in_ready_o(rdy[2]),
      .parallel_i(data[2][7:0]), .serial_o(s2), .frame_o(frm[2]), .frame_start_o(fst[2]),
      .frame_end_o(fend[2]), .frame_count_o(fc[2]));

   function automatic int wid(int i);  return (i == 2) ? 8 : 64; endfunction
   function automatic int lan(int i);  return (i == 1) ? 4 : 1;  endfunction
   function automatic bit msb(int i);  return i != 1;            endfunction
   function automatic int beats(int i); return wid(i) / lan(i);  endfunction

   function automatic logic [3:0] chunk(int i, logic [63:0] w, int b);
      int          sh;
      logic [63:0] t;
      sh = msb(i) ? wid(i) - (b + 1) * lan(i) : b * lan(i);
      t  = (w >> sh) & 64'((1 << lan(i)) - 1);
      return t[3:0];
   endfunction

   // Model: a frame is just "word cur, beat index"; words waiting to start sit in a queue.
   bit          busy [3];
   int          beat [3];
   logic [63:0] cur  [3];
   logic [63:0] pend [3][$];
   int          cnt  [3];
   bit          acc_last [3];

   function automatic bit exp_rdy(int i);
      return rst_n && en && (pend[i].size() == 0 || !busy[i] || beat[i] == beats(i) - 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            busy[i] = 0; beat[i] = 0; cnt[i] = 0; acc_last[i] = 0; pend[i].delete();
         end else if (!en) begin
            acc_last[i] = 0;
         end else begin
            bit last, load;
            last        = busy[i] && beat[i] == beats(i) - 1;
            load        = pend[i].size() > 0 && (!busy[i] || last);
            acc_last[i] = valid[i] && (pend[i].size() == 0 || load);
            if (last) cnt[i] = (cnt[i] + 1) % 65536;
            if (load) begin
               cur[i] = pend[i].pop_front(); beat[i] = 0; busy[i] = 1;
            end else if (last) begin
               busy[i] = 0;
            end else if (busy[i]) begin
               beat[i] = beat[i] + 1;
            end
            if (acc_last[i]) pend[i].push_back(data[i] & ((wid(i) == 64) ? '1 : 64'hFF));
         end
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, i, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk(i, "frame", 64'(frm[i]), 64'(busy[i]));
         chk(i, "serial", 64'(ser[i]), busy[i] ? 64'(chunk(i, cur[i], beat[i])) : 64'd0);
         chk(i, "frame_start", 64'(fst[i]), 64'(busy[i] && beat[i] == 0));
         chk(i, "frame_end", 64'(fend[i]), 64'(busy[i] && beat[i] == beats(i) - 1));
         chk(i, "frame_count", 64'(fc[i]), 64'(cnt[i]));
         chk(i, "in_ready", 64'(rdy[i]), 64'(exp_rdy(i)));
      end
   end

   // Bit collector: beats that will advance (Enable high) are appended; frozen beats are counted apart.
   logic [63:0] coll [3];
   int nb [3], ns [3], ne [3], nfz [3];
   initial for (int i = 0; i < 3; i++) begin coll[i] = 0; nb[i] = 0; ns[i] = 0; ne[i] = 0; nfz[i] = 0; end
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (frm[i] === 1'b1) begin
            if (en) begin
               coll[i] = (coll[i] << lan(i)) | 64'(ser[i]);
               nb[i]++; ns[i] += int'(fst[i]); ne[i] += int'(fend[i]);
            end else begin
               nfz[i]++;
            end
         end
      end
   end

   task automatic send(input int i, input logic [63:0] w);
      bit done;
      done     = 0;
      valid[i] = 1'b1;
      data[i]  = w;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk); #1;
         done = acc_last[i];
      end
      valid[i] = 1'b0;
      if (!done) chk(i, "send_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_beat(input int i, input int b);
      bit done;
      done = busy[i] && beat[i] == b;
      for (int k = 0; k < 300 && !done; k++) begin
         @(posedge clk); #1;
         done = busy[i] && beat[i] == b;
      end
      if (!done) chk(i, "beat_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input int i);
      bit done;
      done = !busy[i] && pend[i].size() == 0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(posedge clk); #1;
         done = !busy[i] && pend[i].size() == 0;
      end
      if (!done) chk(i, "idle_timeout", 64'd0, 64'd1);
   endtask

   int bnb, bns, bne, bfz, bfc;
   logic [63:0] w;

   initial begin
      rst_n = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin valid[i] = 1'b0; data[i] = '0; end
      #1;
      chk(0, "reset_frame", 64'(frm[0]), 64'd0);
      chk(0, "reset_count", 64'(fc[0]), 64'd0);
      chk(0, "reset_ready", 64'(rdy[0]), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single 64-bit word, one lane, MSB first
      bnb = nb[0]; bns = ns[0]; bne = ne[0];
      send(0, 64'hF0F0F0F0F0F0F0F0);
      chk(0, "ready_after_accept", 64'(rdy[0]), 64'd1);
      wait_idle(0);
      chk(0, "t1_bits", coll[0], 64'hF0F0F0F0F0F0F0F0);
      chk(0, "t1_beats", 64'(nb[0] - bnb), 64'd64);
      chk(0, "t1_starts", 64'(ns[0] - bns), 64'd1);
      chk(0, "t1_ends", 64'(ne[0] - bne), 64'd1);
      chk(0, "t1_count", 64'(fc[0]), 64'd1);

      // four lanes, LSB first
      bnb = nb[1];
      send(1, 64'h0123456789ABCDEF);
      wait_idle(1);
      chk(1, "t2_nibbles", coll[1], 64'hFEDCBA9876543210);
      chk(1, "t2_beats", 64'(nb[1] - bnb), 64'd16);
      chk(1, "t2_count", 64'(fc[1]), 64'd1);

      // back-to-back with valid held high
      bnb = nb[2]; bns = ns[2];
      send(2, 64'hA5);
      send(2, 64'h3C);
      wait_idle(2);
      chk(2, "t3_bits", 64'(coll[2][15:0]), 64'hA53C);
      chk(2, "t3_beats", 64'(nb[2] - bnb), 64'd16);
      chk(2, "t3_starts", 64'(ns[2] - bns), 64'd2);
      chk(2, "t3_count", 64'(fc[2]), 64'd2);

      // Enable freeze at beat 3 (bit 4 of 8'h96 is 1)
      bnb = nb[2]; bfz = nfz[2]; bfc = int'(fc[2]);
      send(2, 64'h96);
      wait_beat(2, 3);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk(2, "t4_frozen_frame", 64'(frm[2]), 64'd1);
      chk(2, "t4_frozen_serial", 64'(ser[2]), 64'd1);
      repeat (2) @(posedge clk);
      #1 en = 1'b1;
      wait_idle(2);
      chk(2, "t4_bits", 64'(coll[2][7:0]), 64'h96);
      chk(2, "t4_beats", 64'(nb[2] - bnb), 64'd8);
      chk(2, "t4_frozen", 64'(nfz[2] - bfz), 64'd5);
      chk(2, "t4_count", 64'(int'(fc[2]) - bfc), 64'd1);

      // hold full while shifting: third word waits for the last beat
      bnb = nb[2]; bfc = int'(fc[2]);
      send(2, 64'hC3);
      wait_beat(2, 2);
      send(2, 64'h5A);
      send(2, 64'h7E);
      wait_idle(2);
      chk(2, "t5_bits", 64'(coll[2][23:0]), 64'hC35A7E);
      chk(2, "t5_beats", 64'(nb[2] - bnb), 64'd24);
      chk(2, "t5_count", 64'(int'(fc[2]) - bfc), 64'd3);

      // asynchronous reset at beat 20, between edges
      send(0, {$urandom, $urandom});
      wait_beat(0, 20);
      #1 rst_n = 1'b0;
      #1;
      chk(0, "t6_frame", 64'(frm[0]), 64'd0);
      chk(0, "t6_serial", 64'(s0), 64'd0);
      chk(0, "t6_start", 64'(fst[0]), 64'd0);
      chk(0, "t6_end", 64'(fend[0]), 64'd0);
      chk(0, "t6_count", 64'(fc[0]), 64'd0);
      chk(0, "t6_ready", 64'(rdy[0]), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      bnb = nb[0];
      send(0, 64'hDEADBEEF01234567);
      wait_idle(0);
      chk(0, "t6_bits", coll[0], 64'hDEADBEEF01234567);
      chk(0, "t6_beats", 64'(nb[0] - bnb), 64'd64);
      chk(0, "t6_count_after", 64'(fc[0]), 64'd1);

      // randomized traffic with Enable gaps; per-cycle model comparison does the checking
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #1;
         en = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < 3; i++) begin
            if (!valid[i] || acc_last[i]) begin
               valid[i] = ($urandom_range(0, 2) != 0);
               w        = {$urandom, $urandom};
               data[i]  = w;
            end
         end
      end
      @(posedge clk); #1;
      en = 1'b1;
      for (int i = 0; i < 3; i++) valid[i] = 1'b0;
      for (int i = 0; i < 3; i++) wait_idle(i);
      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
